// File: rtl/acc_shift_i.sv
// Accumulator Shift Unit I: sequences multi-place shift orders and drives the
// x1..x4 gating EMFs into Shift Unit II, one shift step per accumulator circulation.
module acc_shift_i #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_sync,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] places,
  output logic [3:0]       x,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  // x=0000 would clear the accumulator, so every path lands on one of these
  localparam logic [3:0] X_CIRC  = 4'b0110;
  localparam logic [3:0] X_RIGHT = 4'b0101;
  localparam logic [3:0] X_LEFT  = 4'b1010;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] places_r;
  logic             dir_r;
  logic [3:0]       x_r;
  logic             busy_r;
  logic             done_r;
  logic             places_zero_s;
  logic [3:0]       shift_code_s;

  assign places_zero_s = (places == CNT_ZERO);
  assign shift_code_s  = dir_r ? X_LEFT : X_RIGHT;

  // Order sequencing; x only moves on acc_sync edges so it never changes mid-circulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      places_r <= CNT_ZERO;
      dir_r    <= 1'b0;
      x_r      <= X_CIRC;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !places_zero_s) begin
            dir_r    <= dir;
            places_r <= places;
            busy_r   <= 1'b1;
            state_r  <= ARM;
          end else if (start) begin
            done_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ARM: begin
          if (acc_sync) begin
            x_r     <= shift_code_s;
            cnt_r   <= places_r;
            state_r <= SHIFT;
          end else begin
            x_r <= X_CIRC;
          end
        end
        SHIFT: begin
          if (acc_sync && (cnt_r == CNT_ONE)) begin
            x_r     <= X_CIRC;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else if (acc_sync) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          // unreachable encoding: fall back to a harmless circulate
          state_r <= IDLE;
          x_r     <= X_CIRC;
          busy_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign x    = x_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_acc_shift_i.sv
// Directed self-checking bench for acc_shift_i: expected values are hand-derived
// from the order sequencing rules (ARM circulation, then N shift circulations).
module tb_acc_shift_i;

  localparam logic [3:0] CIRC  = 4'b0110;
  localparam logic [3:0] RIGHT = 4'b0101;
  localparam logic [3:0] LEFT  = 4'b1010;
  localparam int CLEN = 72;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       acc_sync;
  logic       start;
  logic       dir;
  logic [5:0] places;
  logic [3:0] x;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  acc_shift_i #(.CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .acc_sync(acc_sync), .start(start),
    .dir(dir), .places(places), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ex, input logic eb, input logic ed);
    check_val({tag, "_x"}, int'(x), int'(ex));
    check_val({tag, "_busy"}, int'(busy), int'(eb));
    check_val({tag, "_done"}, int'(done), int'(ed));
  endtask

  // One circulation: len-1 digits without sync, then the sync digit.
  // x/busy must hold and done stay low on every non-sync digit.
  task automatic run_circ(input int len, input logic [3:0] ex, input logic eb);
    int bad = 0;
    acc_sync = 1'b0;
    for (int i = 0; i < len - 1; i++) begin
      tick();
      if (x !== ex || busy !== eb || done !== 1'b0) bad++;
    end
    acc_sync = 1'b1;
    tick();
    acc_sync = 1'b0;
    check_val("mid_circ_hold", bad, 0);
  endtask

  task automatic issue(input logic d, input logic [5:0] p, input logic sync);
    start = 1'b1; dir = d; places = p; acc_sync = sync;
    tick();
    start = 1'b0; dir = 1'b0; places = 6'd0; acc_sync = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; acc_sync = 1'b0; start = 1'b0; dir = 1'b0; places = 6'd0;
    tick(); tick();
    check_out("reset", CIRC, 1'b0, 1'b0);
    rst_n = 1'b1;

    // idle circulations: nothing moves
    for (int i = 0; i < 5; i++) begin
      run_circ(CLEN, CIRC, 1'b0);
      check_out("idle_sync", CIRC, 1'b0, 1'b0);
    end

    // left, 3 places
    issue(1'b1, 6'd3, 1'b0);
    check_out("l3_accept", CIRC, 1'b1, 1'b0);
    run_circ(CLEN, CIRC, 1'b1);
    check_out("l3_arm_edge", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l3_c1", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l3_c2", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l3_done", CIRC, 1'b0, 1'b1);
    tick();
    check_out("l3_after", CIRC, 1'b0, 1'b0);

    // right, 1 place, start coincident with acc_sync
    issue(1'b0, 6'd1, 1'b1);
    check_out("r1_accept", CIRC, 1'b1, 1'b0);
    run_circ(CLEN, CIRC, 1'b1);
    check_out("r1_arm_edge", RIGHT, 1'b1, 1'b0);
    run_circ(CLEN, RIGHT, 1'b1);
    check_out("r1_done", CIRC, 1'b0, 1'b1);
    tick();
    check_out("r1_after", CIRC, 1'b0, 1'b0);

    // zero places: immediate done, new order accepted in the done cycle
    issue(1'b0, 6'd0, 1'b0);
    check_out("z_done", CIRC, 1'b0, 1'b1);
    issue(1'b1, 6'd4, 1'b0);
    check_out("l4_accept", CIRC, 1'b1, 1'b0);
    run_circ(CLEN, CIRC, 1'b1);
    check_out("l4_arm_edge", LEFT, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    issue(1'b0, 6'd2, 1'b0);
    check_out("l4_ignored", LEFT, 1'b1, 1'b0);
    run_circ(CLEN - 21, LEFT, 1'b1);
    check_out("l4_c1", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l4_c2", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l4_c3", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l4_done", CIRC, 1'b0, 1'b1);
    tick();
    check_out("l4_after", CIRC, 1'b0, 1'b0);

    // reset during the second shift circulation of a 5-place right shift
    issue(1'b0, 6'd5, 1'b0);
    run_circ(CLEN, CIRC, 1'b1);
    check_out("r5_arm_edge", RIGHT, 1'b1, 1'b0);
    run_circ(CLEN, RIGHT, 1'b1);
    check_out("r5_c1", RIGHT, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    check_out("r5_mid_c2", RIGHT, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_out("r5_reset", CIRC, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_circ(CLEN, CIRC, 1'b0);
    check_out("r5_no_resume", CIRC, 1'b0, 1'b0);
    issue(1'b1, 6'd2, 1'b0);
    run_circ(CLEN, CIRC, 1'b1);
    check_out("l2_arm_edge", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l2_c1", LEFT, 1'b1, 1'b0);
    run_circ(CLEN, LEFT, 1'b1);
    check_out("l2_done", CIRC, 1'b0, 1'b1);

    // maximum order: 63 right circulations (short circulations to save time)
    tick();
    issue(1'b0, 6'd63, 1'b0);
    run_circ(8, CIRC, 1'b1);
    check_out("r63_arm_edge", RIGHT, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 62; i++) begin
      run_circ(8, RIGHT, 1'b1);
      if (x !== RIGHT || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check_val("r63_edges", bad, 0);
    run_circ(8, RIGHT, 1'b1);
    check_out("r63_done", CIRC, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_shift_i.md
Name: acc_shift_i

Overview:
Accumulator Shift Unit I. Sequences multi-place accumulator shift orders and drives the four gating EMFs x[3:0] into Shift Unit II, which applies them to the serial accumulator recirculation path.
- One shift step is taken per accumulator circulation, bounded by the circulation sync pulse.
- x[3:0] selects the recirculation delay for that circulation: 1 digit for right, 2 for circulate, 3 for left.
- Sits between the order decoder, which supplies direction and place count, and Shift Unit II.

Parameters:
CNT_W, 6, width of the place-count input and the internal remaining-places counter (max 2^CNT_W-1 places).

Ports:
clk  input  1  system clock, the digit-pulse rate.
rst_n  input  1  synchronous, active-low reset.
acc_sync  input  1  single-cycle pulse in the last digit period of each accumulator circulation.
start  input  1  single-cycle shift order request.
dir  input  1  shift direction, sampled with start: 1 = left (x4 per place), 0 = right.
places  input  CNT_W  number of places to shift, sampled with start.
x  output  4  gating EMFs to Shift Unit II; x[0] maps to x1 ... x[3] maps to x4.
busy  output  1  high while an order is accepted and not yet complete.
done  output  1  single-cycle completion pulse.

Behaviour:
- Gating codes (x[3:0]):
  - CIRC = 4'b0110 (x2, x3): delay 2, no shift.
  - RIGHT = 4'b0101 (x1, x3): delay 1, one place right.
  - LEFT = 4'b1010 (x2, x4): delay 3, one place left.
  - x is registered and always equals exactly one of these three codes. 4'b0000 never appears, because it would clear the accumulator.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, x=CIRC, busy=0, done=0, counter=0, latched dir=0.
  - Reset mid-shift abandons the order immediately. x returns to CIRC on the same edge.
- States: IDLE, ARM, SHIFT.
- IDLE:
  - start=1 with places!=0: latch dir and places, go to ARM, busy=1 from the next cycle.
  - start=1 with places==0: stay in IDLE, busy stays 0, done=1 for one cycle on the next cycle.
  - start and acc_sync in the same IDLE cycle: the order is latched and enters ARM. That acc_sync does not begin shifting.
- ARM:
  - Waits for acc_sync. On the acc_sync edge: x takes the shift code (LEFT if dir else RIGHT), state goes to SHIFT, counter=places.
  - The shift code is therefore effective from the first digit of the next circulation.
- SHIFT:
  - On each acc_sync edge: if counter==1, x=CIRC, state=IDLE, busy=0, done=1 for exactly one cycle. Otherwise counter decrements and x holds.
  - An order of N places therefore holds the shift code for exactly N full circulations.
- x changes only on acc_sync edges or reset; it never changes mid-circulation.
- start while busy=1 is ignored: no latch, no effect on the counter, dir or x.
- A new start is accepted in the same cycle that done is high (state is already IDLE).
- done and busy are never high in the same cycle.
- Counter never wraps. places=2^CNT_W-1 yields exactly 2^CNT_W-1 shift circulations.

Test Plan:
- Reset, no start, 5 acc_sync pulses -> x=0110 throughout; busy=0, done=0.
- start, dir=1, places=3; acc_sync every 72 cycles -> x=1010 for exactly 3 circulations from the first acc_sync after start, then 0110. done pulses once on the third shift-circulation's acc_sync edge. busy is high from start+1 until that edge.
- start, dir=0, places=1 asserted in the same cycle as acc_sync -> no shift on that pulse. x=0101 after the next acc_sync for one circulation, then 0110 with a done pulse.
- start with places=0 -> done high in the next cycle only; x stays 0110, busy stays 0.
- During a 4-place left shift, a second start (dir=0, places=2) is issued mid-order -> it is ignored; exactly 4 LEFT circulations occur and one done pulse follows.
- rst_n=0 in the second SHIFT circulation of a 5-place right shift -> the next edge gives x=0110, busy=0, done=0. A subsequent start with places=2 executes normally.
